// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs : shared definitions for the registered sequential ALU (alu_seq).
//   - Opcode constants OP_PASS_S .. OP_ROL (4-bit Alu_Op encodings)
//   - FSM state encoding state_t (ST_IDLE, ST_EXEC, ST_MUL, ST_DONE)
// ---------------------------------------------------------------------------
package alu_defs;

    localparam logic [3:0] OP_PASS_S = 4'h0;
    localparam logic [3:0] OP_PASS_R = 4'h1;
    localparam logic [3:0] OP_INC    = 4'h2;
    localparam logic [3:0] OP_DEC    = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_SUB    = 4'h5;
    localparam logic [3:0] OP_SHR    = 4'h6;
    localparam logic [3:0] OP_SHL    = 4'h7;
    localparam logic [3:0] OP_AND    = 4'h8;
    localparam logic [3:0] OP_OR     = 4'h9;
    localparam logic [3:0] OP_XOR    = 4'hA;
    localparam logic [3:0] OP_NOT    = 4'hB;
    localparam logic [3:0] OP_NEG    = 4'hC;
    localparam logic [3:0] OP_MUL    = 4'hD;
    localparam logic [3:0] OP_ASR    = 4'hE;
    localparam logic [3:0] OP_ROL    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if : request/result bundle of the sequential ALU.
//   Request : start, Alu_Op[3:0], R[WIDTH-1:0], S[WIDTH-1:0]
//   Result  : Y[WIDTH-1:0], N, Z, C, V, busy, done
//   modport master : the requester (drives start/Alu_Op/R/S)
//   modport slave  : the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();

    logic             start;
    logic [3:0]       Alu_Op;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] Y;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, Alu_Op, R, S,
        input  Y, N, Z, C, V, busy, done
    );

    modport slave (
        input  start, Alu_Op, R, S,
        output Y, N, Z, C, V, busy, done
    );

endinterface

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter : iterative unsigned shift-add multiplier, one partial
// product per step.
//   clk, reset : clock / async active-high reset
//   load       : capture operands a (multiplicand) and b (multiplier)
//   step       : perform one shift-add iteration
//   a, b       : WIDTH-bit unsigned operands
//   count      : iterations completed since load
//   product    : 2*WIDTH-bit product, final after WIDTH steps
//   last       : all WIDTH iterations have been performed
// ---------------------------------------------------------------------------
module alu_mul_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [CNT_W-1:0]     count,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     partial;

    // The low half of prod starts as the multiplier and is shifted out one
    // bit per step while the growing partial sum shifts in from the top.
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        addend  = prod_q[0] ? mcand_q : '0;
        partial = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        if (load) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            count_d = '0;
        end else if (step) begin
            prod_d  = {partial, prod_q[WIDTH-1:1]};
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign product = prod_q;
    assign last    = (count_q == CNT_W'(WIDTH));

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered ALU with start/busy/done handshake and an iterative
// unsigned multiply (opcode 0xD).
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset (aborts any op, no done)
//   bus    : alu_seq_if.slave (start, Alu_Op, R, S in; Y, N, Z, C, V,
//            busy, done out)
// Single-cycle ops complete 2 cycles after start, multiply WIDTH+2 cycles.
// Optional feature macro ALU_OVF_EN: when defined, V reports signed overflow
// for ops 2, 3, 4, 5 and C; otherwise V is tied low.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0] ZERO_EXT = '0;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] r_q, r_d, s_q, s_d, y_q, y_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d;
    logic [WIDTH:0]   alu_res;
    logic             busy, done;

    logic                 mul_load, mul_step, mul_last;
    logic [CNT_W-1:0]     mul_count;
    logic [2*WIDTH-1:0]   mul_product;

    // Multiplier operands come straight from the request so the top-level
    // latches are free to change in the very next cycle.
    assign mul_load = (state_q == ST_IDLE) && bus.start && (bus.Alu_Op == OP_MUL);
    assign mul_step = (state_q == ST_MUL) && (mul_count < CNT_W'(WIDTH));

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .step    (mul_step),
        .a       (bus.R),
        .b       (bus.S),
        .count   (mul_count),
        .product (mul_product),
        .last    (mul_last)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = (bus.Alu_Op == OP_MUL) ? ST_MUL : ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_MUL:  if (mul_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state_q == ST_EXEC) || (state_q == ST_MUL);
        done = (state_q == ST_DONE);
    end

    // Single-cycle op mux on latched operands; bit WIDTH is the C flag.
    always_comb begin
        alu_res = {1'b0, s_q};
        case (op_q)
            OP_PASS_S: alu_res = {1'b0, s_q};
            OP_PASS_R: alu_res = {1'b0, r_q};
            OP_INC:    alu_res = {1'b0, s_q} + ONE_EXT;
            OP_DEC:    alu_res = {1'b0, s_q} - ONE_EXT;
            OP_ADD:    alu_res = {1'b0, r_q} + {1'b0, s_q};
            OP_SUB:    alu_res = {1'b0, r_q} - {1'b0, s_q};
            OP_SHR:    alu_res = {s_q[0], 1'b0, s_q[WIDTH-1:1]};
            OP_SHL:    alu_res = {s_q, 1'b0};
            OP_AND:    alu_res = {1'b0, r_q & s_q};
            OP_OR:     alu_res = {1'b0, r_q | s_q};
            OP_XOR:    alu_res = {1'b0, r_q ^ s_q};
            OP_NOT:    alu_res = {1'b0, ~s_q};
            OP_NEG:    alu_res = ZERO_EXT - {1'b0, s_q};
            OP_ASR:    alu_res = {s_q[0], s_q[WIDTH-1], s_q[WIDTH-1:1]};
            OP_ROL:    alu_res = {s_q, s_q[WIDTH-1]};
            default:   alu_res = {1'b0, s_q};
        endcase
    end

`ifdef ALU_OVF_EN
    logic v_q, v_d;

    // Signed overflow judged from operand and result sign bits only.
    function automatic logic calc_ovf(input logic [3:0] op, input logic r_msb,
                                      input logic s_msb, input logic y_msb);
        case (op)
            OP_INC:  calc_ovf = ~s_msb & y_msb;
            OP_DEC:  calc_ovf = s_msb & ~y_msb;
            OP_ADD:  calc_ovf = (r_msb == s_msb) && (y_msb != r_msb);
            OP_SUB:  calc_ovf = (r_msb != s_msb) && (y_msb != r_msb);
            OP_NEG:  calc_ovf = s_msb & y_msb;
            default: calc_ovf = 1'b0;
        endcase
    endfunction

    // Overflow flag follows the same update timing as the other flags.
    always_comb begin
        v_d = v_q;
        if (state_q == ST_EXEC)
            v_d = calc_ovf(op_q, r_q[WIDTH-1], s_q[WIDTH-1], alu_res[WIDTH-1]);
        else if ((state_q == ST_MUL) && mul_last)
            v_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) v_q <= 1'b0;
        else       v_q <= v_d;
    end

    assign bus.V = v_q;
`else
    assign bus.V = 1'b0;
`endif

    // Operand latches load on an accepted start; result and flags load on
    // the edge that enters DONE and are otherwise held.
    always_comb begin
        op_d = op_q;
        r_d  = r_q;
        s_d  = s_q;
        y_d  = y_q;
        n_d  = n_q;
        z_d  = z_q;
        c_d  = c_q;
        if ((state_q == ST_IDLE) && bus.start) begin
            op_d = bus.Alu_Op;
            r_d  = bus.R;
            s_d  = bus.S;
        end
        if (state_q == ST_EXEC) begin
            y_d = alu_res[WIDTH-1:0];
            c_d = alu_res[WIDTH];
            n_d = alu_res[WIDTH-1];
            z_d = (alu_res[WIDTH-1:0] == '0);
        end else if ((state_q == ST_MUL) && mul_last) begin
            y_d = mul_product[WIDTH-1:0];
            c_d = |mul_product[2*WIDTH-1:WIDTH];
            n_d = mul_product[WIDTH-1];
            z_d = (mul_product[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            r_q  <= '0;
            s_q  <= '0;
            y_q  <= '0;
            n_q  <= 1'b0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            op_q <= op_d;
            r_q  <= r_d;
            s_q  <= s_d;
            y_q  <= y_d;
            n_q  <= n_d;
            z_q  <= z_d;
            c_q  <= c_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.N    = n_q;
    assign bus.Z    = z_q;
    assign bus.C    = c_q;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule
